ex_mem_pipe_stage: RTL and testbench

//   Parametrised EX->MEM pipeline register with valid/ready handshake, optional
//   2-entry skid buffer, synchronous flush and bubble gating. Sits between ALU

---
 rtl/ex_mem_pipe_stage_if.sv | 45 ++++
 rtl/ex_mem_pipe_stage.sv | 99 +++++++++
 tb/tb_ex_mem_pipe_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM stage bus: EX-side op + handshake, MEM-side op + handshake, flush and occupancy.
// master = the stage's environment (EX, hazard unit, MEM), slave = the stage itself.
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_write_in;
  logic                  mem_read_in;
  logic                  reg_write_in;
  logic                  mem_to_reg_in;
  logic [REG_ADDR_W-1:0] reg_dst_in;
  logic                  alu_zero_in;
  logic [DATA_W-1:0]     alu_result_in;
  logic [DATA_W-1:0]     store_data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  mem_write_out;
  logic                  mem_read_out;
  logic                  reg_write_out;
  logic                  mem_to_reg_out;
  logic [REG_ADDR_W-1:0] reg_dst_out;
  logic                  alu_zero_out;
  logic [DATA_W-1:0]     alu_result_out;
  logic [DATA_W-1:0]     store_data_out;
  logic [1:0]            occupancy;

  modport master (
    output flush, in_valid, mem_write_in, mem_read_in, reg_write_in, mem_to_reg_in,
           reg_dst_in, alu_zero_in, alu_result_in, store_data_in, out_ready,
    input  in_ready, out_valid, mem_write_out, mem_read_out, reg_write_out,
           mem_to_reg_out, reg_dst_out, alu_zero_out, alu_result_out, store_data_out,
           occupancy
  );

  modport slave (
    input  flush, in_valid, mem_write_in, mem_read_in, reg_write_in, mem_to_reg_in,
           reg_dst_in, alu_zero_in, alu_result_in, store_data_in, out_ready,
    output in_ready, out_valid, mem_write_out, mem_read_out, reg_write_out,
           mem_to_reg_out, reg_dst_out, alu_zero_out, alu_result_out, store_data_out,
           occupancy
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake and optional skid entry.
// state | meaning
// EMPTY | nothing held, out_valid=0
// BUSY  | main entry holds the op presented to MEM
// FULL  | main + skid both hold ops, in_ready=0 (SKID_EN=1 only)
module ex_mem_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit SKID_EN    = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  ex_mem_pipe_stage_if.slave bus
);

  localparam int PL_W = 2*DATA_W + REG_ADDR_W + 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PL_W-1:0] main_q, main_d;
  logic [PL_W-1:0] skid_q, skid_d;
  logic [PL_W-1:0] in_pl;
  logic            out_valid, skid_valid, in_ready;
  logic            in_fire, out_fire;
  logic            mem_write_h, mem_read_h, reg_write_h;

  assign in_pl = {bus.mem_write_in, bus.mem_read_in, bus.reg_write_in, bus.mem_to_reg_in,
                  bus.alu_zero_in, bus.reg_dst_in, bus.alu_result_in, bus.store_data_in};

  assign out_valid  = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);
  // Skid mode keeps in_ready a pure register decode to break the ready path.
  assign in_ready   = SKID_EN ? ~skid_valid : (bus.out_ready | ~out_valid);
  assign in_fire    = bus.in_valid & in_ready;
  assign out_fire   = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_pl;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_pl;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_pl;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush leaves payload stale; gated controls hide it.
    if (bus.flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {mem_write_h, mem_read_h, reg_write_h, bus.mem_to_reg_out, bus.alu_zero_out,
          bus.reg_dst_out, bus.alu_result_out, bus.store_data_out} = main_q;

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.mem_write_out = mem_write_h & out_valid;
  assign bus.mem_read_out  = mem_read_h  & out_valid;
  assign bus.reg_write_out = reg_write_h & out_valid;
  assign bus.occupancy     = {1'b0, out_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: a skid 32-bit instance and a no-skid 64-bit instance
// share one stimulus; each is checked every cycle against a FIFO-queue model.
module tb_ex_mem_pipe_stage;

  typedef struct packed {
    logic        mw, mr, rw, m2r;
    logic [4:0]  rd;
    logic        z;
    logic [63:0] res, sd;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  op_t  drv = '0;
  int   total = 0, bad = 0;
  int   outs0 = 0, outs1 = 0;
  op_t  q0[$], q1[$];

  always #5 clk = ~clk;

  ex_mem_pipe_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) b0 ();
  ex_mem_pipe_stage_if #(.DATA_W(64), .REG_ADDR_W(5)) b1 ();

  assign b0.flush = flush;          assign b1.flush = flush;
  assign b0.in_valid = in_valid;    assign b1.in_valid = in_valid;
  assign b0.out_ready = out_ready;  assign b1.out_ready = out_ready;
  assign b0.mem_write_in = drv.mw;  assign b1.mem_write_in = drv.mw;
  assign b0.mem_read_in = drv.mr;   assign b1.mem_read_in = drv.mr;
  assign b0.reg_write_in = drv.rw;  assign b1.reg_write_in = drv.rw;
  assign b0.mem_to_reg_in = drv.m2r; assign b1.mem_to_reg_in = drv.m2r;
  assign b0.reg_dst_in = drv.rd;    assign b1.reg_dst_in = drv.rd;
  assign b0.alu_zero_in = drv.z;    assign b1.alu_zero_in = drv.z;
  assign b0.alu_result_in = drv.res[31:0]; assign b1.alu_result_in = drv.res;
  assign b0.store_data_in = drv.sd[31:0];  assign b1.store_data_in = drv.sd;

  ex_mem_pipe_stage #(.DATA_W(32), .REG_ADDR_W(5), .SKID_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  ex_mem_pipe_stage #(.DATA_W(64), .REG_ADDR_W(5), .SKID_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic op_t t32(input op_t o);
    op_t r = o;
    r.res[63:32] = '0;
    r.sd[63:32]  = '0;
    return r;
  endfunction

  // Model: a FIFO of accepted ops; capacity 2 with registered ready, or 1 with pass-through ready.
  always @(posedge clk or negedge rst_n) begin : model
    bit r0, r1, of0, of1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
    end else begin
      r0  = (q0.size() < 2);
      r1  = out_ready || (q1.size() == 0);
      of0 = (q0.size() > 0) && out_ready;
      of1 = (q1.size() > 0) && out_ready;
      if (of0) outs0++;
      if (of1) outs1++;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (of0) void'(q0.pop_front());
        if (in_valid && r0) q0.push_back(t32(drv));
        if (of1) void'(q1.pop_front());
        if (in_valid && r1) q1.push_back(drv);
      end
    end
  end

  task automatic side(input string p, input int n, input bit erdy, input op_t e,
                      input logic ov, input logic [1:0] oc, input logic ir,
                      input logic mw, input logic mr, input logic rw, input logic m2r,
                      input logic z, input logic [4:0] rd,
                      input logic [63:0] res, input logic [63:0] sd);
    bit v;
    v = (n > 0);
    chk({p, "_out_valid"}, 64'(ov), 64'(v));
    chk({p, "_occupancy"}, 64'(oc), 64'(n));
    chk({p, "_in_ready"}, 64'(ir), 64'(erdy));
    chk({p, "_mem_write_out"}, 64'(mw), 64'(v & e.mw));
    chk({p, "_mem_read_out"}, 64'(mr), 64'(v & e.mr));
    chk({p, "_reg_write_out"}, 64'(rw), 64'(v & e.rw));
    if (v || !rst_n) begin
      chk({p, "_mem_to_reg_out"}, 64'(m2r), 64'(e.m2r));
      chk({p, "_alu_zero_out"}, 64'(z), 64'(e.z));
      chk({p, "_reg_dst_out"}, 64'(rd), 64'(e.rd));
      chk({p, "_alu_result_out"}, res, e.res);
      chk({p, "_store_data_out"}, sd, e.sd);
    end
  endtask

  always @(negedge clk) begin : compare
    op_t e0, e1;
    e0 = (q0.size() > 0) ? q0[0] : '0;
    e1 = (q1.size() > 0) ? q1[0] : '0;
    side("d0", q0.size(), q0.size() < 2, e0, b0.out_valid, b0.occupancy, b0.in_ready,
         b0.mem_write_out, b0.mem_read_out, b0.reg_write_out, b0.mem_to_reg_out,
         b0.alu_zero_out, b0.reg_dst_out, 64'(b0.alu_result_out), 64'(b0.store_data_out));
    side("d1", q1.size(), out_ready || (q1.size() == 0), e1, b1.out_valid, b1.occupancy,
         b1.in_ready, b1.mem_write_out, b1.mem_read_out, b1.reg_write_out,
         b1.mem_to_reg_out, b1.alu_zero_out, b1.reg_dst_out, b1.alu_result_out,
         b1.store_data_out);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    #1 chk("rst_in_ready0", 64'(b0.in_ready), 64'd1);
    chk("rst_occ0", 64'(b0.occupancy), 64'd0);

    // Single op then 8-op stream
    drv = '0; drv.res = 64'h10; drv.rd = 5'd3; drv.rw = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk("t1_valid0", 64'(b0.out_valid), 64'd1);
    chk("t1_res0", 64'(b0.alu_result_out), 64'h10);
    chk("t1_occ0", 64'(b0.occupancy), 64'd1);
    for (int i = 0; i < 8; i++) begin
      drv.res = 64'h20 + 64'(i); drv.sd = 64'h100 + 64'(i); drv.rd = 5'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc(); cyc();
    chk("t1_outs0", 64'(outs0), 64'd9);
    chk("t1_outs1", 64'(outs1), 64'd9);

    // Stall: A, B, then C held while FULL
    out_ready = 1'b0; in_valid = 1'b1; drv = '0; drv.res = 64'hA0; drv.mr = 1'b1;
    cyc();
    drv.res = 64'hB0; drv.mr = 1'b0; drv.z = 1'b1;
    cyc();
    chk("t2_occ0", 64'(b0.occupancy), 64'd2);
    chk("t2_ready0", 64'(b0.in_ready), 64'd0);
    chk("t2_res0", 64'(b0.alu_result_out), 64'hA0);
    drv.res = 64'hC0; drv.z = 1'b0;
    cyc(); cyc();
    chk("t3_occ0", 64'(b0.occupancy), 64'd2);
    chk("t3_res0", 64'(b0.alu_result_out), 64'hA0);
    out_ready = 1'b1;
    cyc();
    chk("t2_resB0", 64'(b0.alu_result_out), 64'hB0);
    chk("t2_ready_after0", 64'(b0.in_ready), 64'd1);
    cyc();
    chk("t3_resC0", 64'(b0.alu_result_out), 64'hC0);
    chk("t3_occC0", 64'(b0.occupancy), 64'd1);
    in_valid = 1'b0;
    cyc();
    chk("t3_empty0", 64'(b0.occupancy), 64'd0);

    // Flush while FULL with an incoming op
    out_ready = 1'b0; in_valid = 1'b1; drv = '0; drv.mw = 1'b1; drv.res = 64'hD0;
    cyc();
    drv.res = 64'hE0;
    cyc();
    chk("t4_full0", 64'(b0.occupancy), 64'd2);
    drv.res = 64'hF0; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_occ0", 64'(b0.occupancy), 64'd0);
    chk("t4_valid0", 64'(b0.out_valid), 64'd0);
    chk("t4_mw0", 64'(b0.mem_write_out), 64'd0);
    out_ready = 1'b1; in_valid = 1'b1; drv.res = 64'h77;
    cyc();
    in_valid = 1'b0;
    chk("t4_next_res0", 64'(b0.alu_result_out), 64'h77);
    chk("t4_next_mw0", 64'(b0.mem_write_out), 64'd1);
    cyc();
    chk("t5_bubble_mw0", 64'(b0.mem_write_out), 64'd0);

    // Async reset during a stall
    out_ready = 1'b0; in_valid = 1'b1; drv = '0; drv.rw = 1'b1; drv.res = 64'h55;
    cyc();
    drv.res = 64'h66;
    cyc();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("t5_rst_valid0", 64'(b0.out_valid), 64'd0);
    chk("t5_rst_occ0", 64'(b0.occupancy), 64'd0);
    chk("t5_rst_rw0", 64'(b0.reg_write_out), 64'd0);
    chk("t5_rst_res0", 64'(b0.alu_result_out), 64'd0);
    chk("t5_rst_valid1", 64'(b1.out_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    #1 chk("t5_rel_ready0", 64'(b0.in_ready), 64'd1);

    // 64-bit payload through the no-skid instance, combinational ready
    cyc();
    drv = '0; drv.res = 64'hDEAD_BEEF_0123_4567; drv.sd = 64'h0123_4567_89AB_CDEF;
    in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk("t6_res1", b1.alu_result_out, 64'hDEAD_BEEF_0123_4567);
    chk("t6_sd1", b1.store_data_out, 64'h0123_4567_89AB_CDEF);
    chk("t6_res0", 64'(b0.alu_result_out), 64'h0123_4567);
    chk("t6_ready_lo1", 64'(b1.in_ready), 64'd0);
    out_ready = 1'b1;
    #1 chk("t6_ready_hi1", 64'(b1.in_ready), 64'd1);
    out_ready = 1'b0;
    #1 chk("t6_ready_lo1b", 64'(b1.in_ready), 64'd0);
    out_ready = 1'b1;
    cyc(); cyc();
    chk("t6_drained1", 64'(b1.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
